issue_scoreboard: RTL and testbench

- Per-register pending-write tracker and stall controller between decode and execute in the pipelined MIPS-style core.
- Tracks the remaining latency of every in-flight GPR/FPR write, using the same 6-bit register tags as decode (bit 5 = FPR).
- Asserts stall when an issuing instruction would read a not-yet-forwardable result, would overtake an older write to the same register, or needs the shared non-pipelined long-latency unit (div/inv/sqrt) while it is occupied.

---
 rtl/issue_scoreboard_pkg.sv | 29 ++
 rtl/issue_scoreboard_lat_counter.sv | 28 ++
 rtl/issue_scoreboard.sv | 95 +++++++++
 tb/tb_issue_scoreboard.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared decode/issue constants: register tags, write-class encodings and
// the result latencies used by decode when it computes wait_time.
package issue_scoreboard_pkg;

   localparam int NREG    = 64;
   localparam int WT_W    = 5;
   localparam int FWD_LAT = 1;

   // Tag layout is {is_fpr, idx[4:0]}; tag 0 is GPR0, which is hardwired to zero.
   typedef logic [5:0] reg_tag_t;

   typedef enum logic [1:0] {
      RW_NONE = 2'b00,
      RW_GPR  = 2'b01,
      RW_FPR  = 2'b10,
      RW_RSVD = 2'b11
   } rw_class_e;

   localparam logic [WT_W-1:0] LAT_LW   = 5'd4;
   localparam logic [WT_W-1:0] LAT_FADD = 5'd4;
   localparam logic [WT_W-1:0] LAT_FMUL = 5'd6;
   localparam logic [WT_W-1:0] LAT_MULT = 5'd5;
   localparam logic [WT_W-1:0] LAT_LONG = 5'd31;

   function automatic reg_tag_t make_tag(input logic is_fpr, input logic [4:0] idx);
      return {is_fpr, idx};
   endfunction

endpackage

// File: rtl/issue_scoreboard_lat_counter.sv
// Load / decrement-to-zero latency counter with a registered-value
// "greater than threshold" flag used for the hazard checks.
module lat_counter #(
   parameter int WT_W   = 5,
   parameter int THRESH = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            load,
   input  logic [WT_W-1:0] load_val,
   output logic [WT_W-1:0] cnt,
   output logic            gt
);

   // A new load always wins over the running decrement.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign gt = (cnt > WT_W'(THRESH));

endmodule

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard between decode and execute: one latency counter
// per register tag plus one for the shared long-latency unit, and the stall.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            issue_valid,
   input  logic [5:0]      rs,
   input  logic            rs_used,
   input  logic [5:0]      rt,
   input  logic            rt_used,
   input  logic [1:0]      rw,
   input  logic [4:0]      rd,
   input  logic [4:0]      wait_time,
   input  logic            long_op,
   output logic            stall,
   output logic [NREG-1:0] busy_mask,
   output logic            long_busy,
   output logic [31:0]     stall_cycles
);

   localparam int NCNT     = NREG + 1;
   localparam int LONG_IDX = NREG;

   reg_tag_t        dest;
   logic            write_tracked;
   logic            fire;
   logic            raw_hazard;
   logic            waw_hazard;
   logic            struct_hazard;
   logic [WT_W-1:0] load_val;
   logic [NCNT-1:0] load;
   logic [NCNT-1:0] gt;
   logic [WT_W-1:0] cnt [NCNT];

   // Counters hold the cycles remaining after the issue cycle, so a producer
   // of latency W is loaded with W-1 and a consumer can fire W-FWD_LAT later.
   always_comb begin
      dest          = make_tag(rw == RW_FPR, rd);
      write_tracked = ((rw == RW_GPR) || (rw == RW_FPR)) && (dest != '0) && (wait_time != '0);
      load_val      = (wait_time == '0) ? '0 : wait_time - 1'b1;
   end

   always_comb begin
      raw_hazard    = (rs_used && (rs != '0) && gt[{1'b0, rs}]) ||
                      (rt_used && (rt != '0) && gt[{1'b0, rt}]);
      waw_hazard    = write_tracked && (cnt[{1'b0, dest}] > wait_time);
      struct_hazard = long_op && gt[LONG_IDX];
      stall         = issue_valid && (raw_hazard || waw_hazard || struct_hazard);
      fire          = issue_valid && !stall;
   end

   always_comb begin
      load = '0;
      if (fire && write_tracked) begin
         load[{1'b0, dest}] = 1'b1;
      end
      if (fire && long_op) begin
         load[LONG_IDX] = 1'b1;
      end
   end

   // Entries 0..NREG-1 are register tags; the last entry is the long unit.
   for (genvar r = 0; r < NCNT; r++) begin : g_cnt
      lat_counter #(
         .WT_W   (WT_W),
         .THRESH ((r == LONG_IDX) ? 1 : FWD_LAT)
      ) u_cnt (
         .clk      (clk),
         .rstn     (rstn),
         .load     (load[r]),
         .load_val (load_val),
         .cnt      (cnt[r]),
         .gt       (gt[r])
      );
   end

   always_comb begin
      busy_mask = '0;
      for (int r = 0; r < NREG; r++) begin
         busy_mask[r] = (cnt[r] != '0);
      end
      long_busy = gt[LONG_IDX];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a vector table driven through an
// expected-result queue, plus hand sequences for long-unit and reset cases.
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

   logic        clk;
   logic        rstn;
   logic        issue_valid;
   logic [5:0]  rs;
   logic        rs_used;
   logic [5:0]  rt;
   logic        rt_used;
   logic [1:0]  rw;
   logic [4:0]  rd;
   logic [4:0]  wait_time;
   logic        long_op;
   logic        stall;
   logic [63:0] busy_mask;
   logic        long_busy;
   logic [31:0] stall_cycles;

   typedef struct {
      logic        iv;
      logic [5:0]  rs;
      logic        rsu;
      logic [5:0]  rt;
      logic        rtu;
      logic [1:0]  rw;
      logic [4:0]  rd;
      logic [4:0]  wt;
      logic        lo;
      logic        exp_stall;
      logic [63:0] exp_busy;
   } vec_t;

   localparam logic [63:0] B8  = 64'd1 << 8;
   localparam logic [63:0] B37 = 64'd1 << 37;

   vec_t table_q[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   issue_scoreboard dut (
      .clk          (clk),
      .rstn         (rstn),
      .issue_valid  (issue_valid),
      .rs           (rs),
      .rs_used      (rs_used),
      .rt           (rt),
      .rt_used      (rt_used),
      .rw           (rw),
      .rd           (rd),
      .wait_time    (wait_time),
      .long_op      (long_op),
      .stall        (stall),
      .busy_mask    (busy_mask),
      .long_busy    (long_busy),
      .stall_cycles (stall_cycles)
   );

   // 10 ns clock; inputs change on the falling edge, checks land 1 ns before rising.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic iv, input logic [5:0] vrs, input logic vrsu,
                               input logic [5:0] vrt, input logic vrtu, input logic [1:0] vrw,
                               input logic [4:0] vrd, input logic [4:0] vwt, input logic vlo,
                               input logic es, input logic [63:0] eb);
      vec_t v;
      v.iv = iv; v.rs = vrs; v.rsu = vrsu; v.rt = vrt; v.rtu = vrtu;
      v.rw = vrw; v.rd = vrd; v.wt = vwt; v.lo = vlo;
      v.exp_stall = es; v.exp_busy = eb;
      return v;
   endfunction

   function automatic vec_t idle(input logic [63:0] eb);
      return mk(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, RW_NONE, 5'd0, 5'd0, 1'b0, 1'b0, eb);
   endfunction

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      issue_valid = v.iv;
      rs          = v.rs;
      rs_used     = v.rsu;
      rt          = v.rt;
      rt_used     = v.rtu;
      rw          = v.rw;
      rd          = v.rd;
      wait_time   = v.wt;
      long_op     = v.lo;
      exp_q.push_back(v);
   endtask

   task automatic checkOutput(input string tag);
      vec_t e;
      #4;
      if (exp_q.size() == 0) begin
         checkValue({tag, " scoreboard empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         checkValue({tag, " stall"}, {63'd0, stall}, {63'd0, e.exp_stall});
         checkValue({tag, " busy_mask"}, busy_mask, e.exp_busy);
      end
   endtask

   initial begin
      int   n_stall;
      logic fired;

      rstn = 1'b0;
      issue_valid = 1'b0; rs = '0; rs_used = 1'b0; rt = '0; rt_used = 1'b0;
      rw = RW_NONE; rd = '0; wait_time = '0; long_op = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      checkValue("reset stall", {63'd0, stall}, 64'd0);
      checkValue("reset busy_mask", busy_mask, 64'd0);
      checkValue("reset long_busy", {63'd0, long_busy}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < 10; i++) table_q.push_back(idle(64'd0));

      // lw r8 (W=4) then readers through rs, rt, rs: two stalls, fire on cnt=1
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_GPR, 5'd8, LAT_LW, 0, 0, 64'd0));
      table_q.push_back(mk(1, 6'd8, 1, 6'd0, 0, RW_GPR, 5'd9, 5'd1, 0, 1, B8));
      table_q.push_back(mk(1, 6'd0, 0, 6'd8, 1, RW_GPR, 5'd9, 5'd1, 0, 1, B8));
      table_q.push_back(mk(1, 6'd8, 1, 6'd0, 0, RW_GPR, 5'd9, 5'd1, 0, 0, B8));
      table_q.push_back(idle(64'd0));

      // fmul f5 (W=6) then fadd f5 (W=4): one WAW stall, then three busy cycles
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_FPR, 5'd5, LAT_FMUL, 0, 0, 64'd0));
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_FPR, 5'd5, LAT_FADD, 0, 1, B37));
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_FPR, 5'd5, LAT_FADD, 0, 0, B37));
      table_q.push_back(idle(B37));
      table_q.push_back(idle(B37));
      table_q.push_back(idle(B37));
      table_q.push_back(idle(64'd0));

      // single-cycle producer never stalls its consumer
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_GPR, 5'd10, 5'd1, 0, 0, 64'd0));
      table_q.push_back(mk(1, 6'd10, 1, 6'd0, 0, RW_NONE, 5'd0, 5'd0, 0, 0, 64'd0));

      // GPR0 destination and reserved write class are never tracked
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_GPR, 5'd0, 5'd4, 0, 0, 64'd0));
      table_q.push_back(mk(1, 6'd0, 1, 6'd0, 1, RW_NONE, 5'd0, 5'd0, 0, 0, 64'd0));
      table_q.push_back(mk(1, 6'd0, 0, 6'd0, 0, RW_RSVD, 5'd3, 5'd4, 0, 0, 64'd0));
      table_q.push_back(mk(1, 6'd3, 1, 6'd3, 1, RW_NONE, 5'd0, 5'd0, 0, 0, 64'd0));
      table_q.push_back(idle(64'd0));

      foreach (table_q[i]) begin
         applyStimulus(table_q[i]);
         checkOutput($sformatf("vec%0d", i));
      end
      checkValue("stall_cycles after RAW/WAW", {32'd0, stall_cycles}, 64'd3);

      // div (W=31) fires, then finv waits on the long unit until lcnt == 1
      applyStimulus(mk(1, 6'd0, 0, 6'd0, 0, RW_NONE, 5'd0, LAT_LONG, 1, 0, 64'd0));
      checkOutput("div issue");
      @(negedge clk);
      issue_valid = 1'b1; long_op = 1'b1; wait_time = LAT_LONG; rw = RW_NONE;
      rs_used = 1'b0; rt_used = 1'b0;
      n_stall = 0;
      fired   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #4;
         if (!stall) begin
            fired = 1'b1;
            break;
         end
         n_stall++;
         checkValue("long_busy while finv stalled", {63'd0, long_busy}, 64'd1);
         @(negedge clk);
      end
      checkValue("finv fired within bound", {63'd0, fired}, 64'd1);
      checkValue("structural stall length", n_stall, 64'd29);

      applyStimulus(idle(64'd0));
      checkOutput("after finv");
      checkValue("stall_cycles after structural", {32'd0, stall_cycles}, 64'd32);
      checkValue("long_busy after finv", {63'd0, long_busy}, 64'd1);
      for (int i = 0; i < 28; i++) begin
         applyStimulus(idle(64'd0));
         checkOutput("long drain");
      end
      applyStimulus(mk(1, 6'd0, 0, 6'd0, 0, RW_NONE, 5'd0, 5'd2, 1, 0, 64'd0));
      checkOutput("back-to-back long op at lcnt=1");
      checkValue("long_busy at lcnt=1", {63'd0, long_busy}, 64'd0);

      // reset asserted mid-cycle while a RAW stall is pending
      applyStimulus(mk(1, 6'd0, 0, 6'd0, 0, RW_GPR, 5'd8, LAT_LW, 0, 0, 64'd0));
      checkOutput("lw before reset");
      @(negedge clk);
      issue_valid = 1'b1; rs = 6'd8; rs_used = 1'b1; rt_used = 1'b0;
      rw = RW_NONE; rd = '0; wait_time = '0; long_op = 1'b0;
      #2;
      checkValue("stall before async reset", {63'd0, stall}, 64'd1);
      checkValue("busy_mask before async reset", busy_mask, B8);
      #1;
      rstn = 1'b0;
      #1;
      checkValue("stall after async reset", {63'd0, stall}, 64'd0);
      checkValue("busy_mask after async reset", busy_mask, 64'd0);
      checkValue("stall_cycles after async reset", {32'd0, stall_cycles}, 64'd0);
      @(negedge clk);
      issue_valid = 1'b0; rs_used = 1'b0;
      rstn = 1'b1;
      applyStimulus(idle(64'd0));
      checkOutput("idle after reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
